// File: rtl/dct_pkg.sv
// Shared definitions for the 8x8 2-D DCT sequencer.
//   DCT_N   : block edge length (rows per block, samples per row)
//   DATA_W  : default sample / coefficient width
//   state_t : sequencer FSM states
//   pass_t  : which pass a vector in flight through the engine belongs to
//   tag_t   : per-vector tag carried alongside the engine latency
package dct_pkg;

    localparam int DCT_N  = 8;
    localparam int DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        ROW_LOAD,
        ROW_DRAIN,
        COL_ISSUE
    } state_t;

    typedef enum logic {
        ROW = 1'b0,
        COL = 1'b1
    } pass_t;

    typedef struct packed {
        logic       valid;
        pass_t      pass;
        logic [2:0] idx;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, pass: ROW, idx: 3'd0};

endpackage

// File: rtl/dct_transpose_buf.sv
// 8x8 transpose buffer between the row and column passes.
//   clk     : clock
//   wr_en   : write one full row this cycle
//   wr_row  : row index written
//   wr_data : row samples, sample k at [k*DATA_W +: DATA_W]
//   rd_col  : column index read (combinational)
//   rd_data : column samples, row r at [r*DATA_W +: DATA_W]
// Contents are intentionally not reset: every row is rewritten before
// any column of the same block is read.
module dct_transpose_buf #(
    parameter int DATA_W = 12
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [2:0]          wr_row,
    input  logic [8*DATA_W-1:0] wr_data,
    input  logic [2:0]          rd_col,
    output logic [8*DATA_W-1:0] rd_data
);
    import dct_pkg::*;

    logic [DATA_W-1:0] mem_reg [DCT_N][DCT_N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < DCT_N; k++) begin
                mem_reg[wr_row][k] <= wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DCT_N; gi++) begin : g_rd
            assign rd_data[gi*DATA_W +: DATA_W] = mem_reg[gi][rd_col];
        end
    endgenerate

endmodule

// File: rtl/dct2d_sched.sv
// 8x8 2-D DCT sequencer around one shared 1-D DCT engine.
// Accepts eight rows (valid/ready), issues each to the engine, collects
// the row results in a transpose buffer, then issues the eight columns
// through the same engine and streams out the column coefficients.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_valid/i_data/o_ready   : upstream row stream
//   o_dct_valid/o_dct_data   : engine issue port
//   i_dct_data               : engine result, DCT_LAT cycles after issue
//   o_valid/o_col_idx/o_data : column results (no backpressure)
//   o_block_done             : pulse with column 7 output
//   o_busy                   : not idle or results still in flight
module dct2d_sched #(
    parameter int DATA_W  = 12,
    parameter int DCT_LAT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [8*DATA_W-1:0] i_data,
    output logic                o_ready,
    output logic                o_dct_valid,
    output logic [8*DATA_W-1:0] o_dct_data,
    input  logic [8*DATA_W-1:0] i_dct_data,
    output logic                o_valid,
    output logic [2:0]          o_col_idx,
    output logic [8*DATA_W-1:0] o_data,
    output logic                o_block_done,
    output logic                o_busy
);
    import dct_pkg::*;

    state_t              state_reg, state_next;
    logic [2:0]          row_cnt_reg, row_cnt_next;
    logic [2:0]          col_cnt_reg, col_cnt_next;

    logic                row_issue_valid_reg;
    logic [2:0]          row_issue_idx_reg;
    logic [8*DATA_W-1:0] row_issue_data_reg;

    tag_t                tag_pipe_reg [DCT_LAT];
    tag_t                issue_tag;
    tag_t                tail_tag;

    logic                accept;
    logic                col_issue;
    logic                row_retire;
    logic                col_retire;
    logic                tags_in_flight;
    logic [8*DATA_W-1:0] col_data;

    logic                out_valid_reg;
    logic [2:0]          out_col_idx_reg;
    logic [8*DATA_W-1:0] out_data_reg;
    logic                out_block_done_reg;

    // Ready is gated by reset so nothing is accepted while the
    // sequencer is being cleared.
    assign o_ready   = !i_rst && (state_reg == IDLE || state_reg == ROW_LOAD);
    assign accept    = i_valid && o_ready;
    assign col_issue = (state_reg == COL_ISSUE);

    assign tail_tag   = tag_pipe_reg[DCT_LAT-1];
    assign row_retire = tail_tag.valid && (tail_tag.pass == ROW);
    assign col_retire = tail_tag.valid && (tail_tag.pass == COL);

    // Row issues and column issues never overlap: the last row is issued
    // on entry to ROW_DRAIN, long before COL_ISSUE is reached.
    always_comb begin
        issue_tag = TAG_NONE;
        if (row_issue_valid_reg) begin
            issue_tag = '{valid: 1'b1, pass: ROW, idx: row_issue_idx_reg};
        end else if (col_issue) begin
            issue_tag = '{valid: 1'b1, pass: COL, idx: col_cnt_reg};
        end
    end

    assign o_dct_valid = issue_tag.valid;
    assign o_dct_data  = col_issue ? col_data : row_issue_data_reg;

    always_comb begin
        state_next   = state_reg;
        row_cnt_next = row_cnt_reg;
        col_cnt_next = col_cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    row_cnt_next = 3'd1;
                    state_next   = ROW_LOAD;
                end
            end
            ROW_LOAD: begin
                if (accept) begin
                    row_cnt_next = row_cnt_reg + 3'd1;
                    if (row_cnt_reg == 3'd7) begin
                        state_next = ROW_DRAIN;
                    end
                end
            end
            ROW_DRAIN: begin
                if (row_retire && tail_tag.idx == 3'd7) begin
                    col_cnt_next = 3'd0;
                    state_next   = COL_ISSUE;
                end
            end
            COL_ISSUE: begin
                col_cnt_next = col_cnt_reg + 3'd1;
                if (col_cnt_reg == 3'd7) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            row_cnt_reg <= 3'd0;
            col_cnt_reg <= 3'd0;
        end else begin
            state_reg   <= state_next;
            row_cnt_reg <= row_cnt_next;
            col_cnt_reg <= col_cnt_next;
        end
    end

    // Accepted rows are registered and issued one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_issue_valid_reg <= 1'b0;
            row_issue_idx_reg   <= 3'd0;
            row_issue_data_reg  <= '0;
        end else begin
            row_issue_valid_reg <= accept;
            if (accept) begin
                row_issue_idx_reg  <= (state_reg == IDLE) ? 3'd0 : row_cnt_reg;
                row_issue_data_reg <= i_data;
            end
        end
    end

    // The tag is captured in its issue cycle, so after DCT_LAT stages it
    // sits at the tail exactly when the engine presents that result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DCT_LAT; i++) begin
                tag_pipe_reg[i] <= TAG_NONE;
            end
        end else begin
            tag_pipe_reg[0] <= issue_tag;
            for (int i = 1; i < DCT_LAT; i++) begin
                tag_pipe_reg[i] <= tag_pipe_reg[i-1];
            end
        end
    end

    always_comb begin
        tags_in_flight = 1'b0;
        for (int i = 0; i < DCT_LAT; i++) begin
            tags_in_flight = tags_in_flight | tag_pipe_reg[i].valid;
        end
    end

    assign o_busy = (state_reg != IDLE) || row_issue_valid_reg || tags_in_flight;

    dct_transpose_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (i_clk),
        .wr_en   (row_retire),
        .wr_row  (tail_tag.idx),
        .wr_data (i_dct_data),
        .rd_col  (col_cnt_reg),
        .rd_data (col_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_reg      <= 1'b0;
            out_col_idx_reg    <= 3'd0;
            out_data_reg       <= '0;
            out_block_done_reg <= 1'b0;
        end else begin
            out_valid_reg      <= col_retire;
            out_block_done_reg <= col_retire && (tail_tag.idx == 3'd7);
            if (col_retire) begin
                out_col_idx_reg <= tail_tag.idx;
                out_data_reg    <= i_dct_data;
            end
        end
    end

    assign o_valid      = out_valid_reg;
    assign o_col_idx    = out_col_idx_reg;
    assign o_data       = out_data_reg;
    assign o_block_done = out_block_done_reg;

endmodule

// File: doc/dct2d_sched.md
# dct2d_sched

Sequencer that runs a complete 8x8 2-D DCT on one shared 1-D DCT engine. It accepts eight 8-sample rows from the upstream stream with valid/ready and issues each to the engine. It collects the row results in a transpose buffer, then issues the eight columns through the same engine and streams out the column coefficients. It sits between the block-row source and the `row_dct` engine instance; downstream quantisation consumes its output.

## Interface
Parameters:
- `DATA_W`, 12: sample and coefficient width, two's complement.
- `DCT_LAT`, 4: engine latency. A vector issued in cycle t has its result on `i_dct_data` in cycle t+DCT_LAT.

Ports:
- `i_clk`, in, 1: sole clock, rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_valid`, in, 1: upstream row valid.
- `i_data`, in, 8*DATA_W: upstream row. Sample k is at bits [k*DATA_W +: DATA_W].
- `o_ready`, out, 1: row accepted on `i_valid && o_ready`.
- `o_dct_valid`, out, 1: engine issue strobe.
- `o_dct_data`, out, 8*DATA_W: engine input vector.
- `i_dct_data`, in, 8*DATA_W: engine output vector, in natural coefficient order.
- `o_valid`, out, 1: column result valid. No backpressure; downstream must accept every cycle.
- `o_col_idx`, out, 3: column index of `o_data`.
- `o_data`, out, 8*DATA_W: 2-D coefficients of column `o_col_idx`, rows 0..7.
- `o_block_done`, out, 1: one-cycle pulse, coincident with `o_valid` for column 7.
- `o_busy`, out, 1: high when the state is not IDLE, or when any engine result is in flight.

## Operation
- FSM states:
  - IDLE
  - ROW_LOAD
  - ROW_DRAIN
  - COL_ISSUE
- `o_ready` is combinational: 1 in IDLE and ROW_LOAD, 0 otherwise. It is never high during reset.
- IDLE → ROW_LOAD on accept; that row becomes row 0 and the 3-bit row counter is set to 1.
- ROW_LOAD: each accept increments the row counter. Gaps in `i_valid` are allowed. On the 8th accept, go to ROW_DRAIN.
- Each accepted row is registered: `o_dct_valid=1` and `o_dct_data=row` in the next cycle.
- Tag pipeline: DCT_LAT stages of {valid, pass (row/col), idx[2:0]}. It is pushed in every issue cycle, shifts every cycle, and does not depend on any engine valid output.
- Tag at the tail with pass=row, idx=r: `i_dct_data` is written into transpose-buffer row r at the end of that cycle.
- ROW_DRAIN → COL_ISSUE in the cycle after the row-7 tag retires.
- COL_ISSUE runs 8 consecutive cycles, c=0..7. It issues `o_dct_data` = {buf[7][c], …, buf[0][c]}, with buf[0][c] in the lowest slice, and pushes tag (col, c).
- After column 7 is issued, COL_ISSUE → IDLE. The next block's rows may be accepted while column results are still in flight.
- Tag at the tail with pass=col, idx=c: in the next cycle, `o_valid=1`, `o_col_idx=c`, `o_data=i_dct_data` registered. `o_block_done=1` when c=7.
- Arithmetic: pure data movement, no scaling, rounding or width change.
- The buffer is never read and written in the same cycle. The column reads complete before the next block's first row result can retire, because that row is issued ≥1 cycle after column 7.

## Timing
- Reset values:
  - `o_dct_valid`=0, `o_dct_data`=0
  - `o_valid`=0, `o_col_idx`=0, `o_data`=0
  - `o_block_done`=0, `o_busy`=0
  - state IDLE, counters 0, tag pipeline cleared.
- Transpose-buffer contents are not reset.
- With DCT_LAT=4 and back-to-back rows accepted in cycles A..A+7:
  - Row issues: A+1..A+8.
  - Row-7 result: A+12.
  - Column issues: A+13..A+20.
  - `o_valid` cycles: A+18..A+25.
  - `o_block_done`: A+25.
  - `o_ready` deasserts A+8..A+20 and returns at A+21.
- Minimum block period: 21 cycles. This is 8 + DCT_LAT + 8 + 1 in general.
- Reset mid-block: the partial block is dropped and in-flight tags are discarded. No `o_valid` is produced for any result that returns after reset; engine outputs are ignored.
- A row accept in the same cycle as a column-result output is legal. The two are independent.

## Structure
- Shared package `dct_pkg` holds:
  - `DCT_N=8` and `DATA_W`.
  - The FSM state enum.
  - The tag struct {valid, pass, idx}.
  - Pass encodings ROW=0, COL=1.
- One sub-module: `dct_transpose_buf`, an 8x8xDATA_W register array with a row-write port and a column-read port (combinational read).
- Engine instantiation stays outside this block; the parent wires it up.

## Test plan
- Identity engine model (DCT_LAT=4, output = input delayed by 4), rows row r = {8r+k}, k=0..7, accepted back-to-back from A:
  - `o_data` for column c = {56+c, …, 8+c, c} in cycles A+18+c.
  - `o_block_done` at A+25.
  - `o_ready` low A+8..A+20.
- Upstream gaps (`i_valid` every other cycle):
  - Identical output values.
  - Column issue starts DCT_LAT+1 cycles after the 8th row is issued.
- Two blocks back-to-back:
  - Second-block rows are accepted from A+21.
  - Outputs of both blocks are correct and in order, with no buffer corruption.
  - Exactly 16 `o_valid` cycles and 2 `o_block_done` pulses.
- `i_valid` held high while `o_ready`=0: no extra accepts, and the row counter is unchanged.
- `i_rst` asserted during COL_ISSUE (column 3 issued):
  - All outputs go to 0 the next cycle.
  - No `o_valid` appears afterwards.
  - A fresh block then completes correctly.
- DCT_LAT=1 and DCT_LAT=7 parameter runs: the same data checks as the first scenario, with latencies shifted by DCT_LAT.
